sprite_motion_ctrl: RTL and testbench

Per-frame motion scheduler for up to NUM_SPRITES hardware sprites, running in the pixel-clock domain. On each rising edge of vertical blank it walks the sprite register file one sprite per cycle, applies velocity with bounce-at-bounds, and presents updated coordinates to the sprite renderers. A config write port lets a host set any sprite's position or velocity between frames. Sprite position updates stay synchronous to the pixel clock.

---
 rtl/sprite_pkg.sv | 17 +
 rtl/sprite_axis_step.sv | 35 +++
 rtl/sprite_motion_ctrl.sv | 148 ++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite motion scheduler: config field codes and FSM state type.
package sprite_pkg;

  localparam logic [1:0] CFG_X    = 2'd0;
  localparam logic [1:0] CFG_Y    = 2'd1;
  localparam logic [1:0] CFG_XVEL = 2'd2;
  localparam logic [1:0] CFG_YVEL = 2'd3;

  // ST_RESET is never held; it only falls straight through to ST_IDLE.
  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis motion step: pos + vel with bounce at [0, MAX), velocity negation saturating.
module sprite_axis_step #(
  parameter int COORD_W = 16
) (
  input  logic signed [COORD_W-1:0] i_pos,
  input  logic signed [COORD_W-1:0] i_vel,
  input  logic signed [COORD_W:0]   i_max,
  output logic signed [COORD_W-1:0] o_pos,
  output logic signed [COORD_W-1:0] o_vel
);

  localparam logic signed [COORD_W-1:0] MOST_NEG = {1'b1, {(COORD_W-1){1'b0}}};
  localparam logic signed [COORD_W-1:0] MOST_POS = {1'b0, {(COORD_W-1){1'b1}}};

  logic signed [COORD_W:0]   next_pos;
  logic signed [COORD_W:0]   max_m1;
  logic signed [COORD_W-1:0] neg_vel;

  always_comb begin
    // One extra bit so the sum of two extreme values never wraps.
    next_pos = {i_pos[COORD_W-1], i_pos} + {i_vel[COORD_W-1], i_vel};
    max_m1   = i_max - {{COORD_W{1'b0}}, 1'b1};
    neg_vel  = (i_vel == MOST_NEG) ? MOST_POS : -i_vel;
    o_pos    = next_pos[COORD_W-1:0];
    o_vel    = i_vel;
    if (next_pos >= i_max) begin
      o_pos = max_m1[COORD_W-1:0];
      o_vel = neg_vel;
    end else if (next_pos[COORD_W]) begin
      o_pos = '0;
      o_vel = neg_vel;
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion scheduler: on each vblank rising edge, steps one sprite per cycle.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int COORD_W     = 16,
  parameter int X_MAX       = 200,
  parameter int Y_MAX       = 150,
  parameter int RST_X_VEL   = 3,
  parameter int RST_Y_VEL   = 2,
  localparam int IDX_W      = $clog2(NUM_SPRITES)
) (
  input  logic                           i_pix_clk,
  input  logic                           i_reset,
  input  logic                           i_vert_blank,
  input  logic                           i_cfg_valid,
  input  logic [IDX_W-1:0]               i_cfg_sprite,
  input  logic [1:0]                     i_cfg_field,
  input  logic [COORD_W-1:0]             i_cfg_data,
  output logic                           o_cfg_ready,
  output logic [NUM_SPRITES*COORD_W-1:0] o_x_coords,
  output logic [NUM_SPRITES*COORD_W-1:0] o_y_coords,
  output logic                           o_busy,
  output logic                           o_frame_done,
  output logic [15:0]                    o_frame_count,
  output state_t                         o_dbg_state
);

  localparam logic signed [COORD_W:0] X_MAX_S = (COORD_W+1)'(X_MAX);
  localparam logic signed [COORD_W:0] Y_MAX_S = (COORD_W+1)'(Y_MAX);

  // Handshake: a config write transfers on a clock edge where i_cfg_valid && o_cfg_ready;
  // the requester must hold valid and its payload stable until that edge.
  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      vblank_q;
  logic [15:0]               count_q, count_d;
  logic signed [COORD_W-1:0] x_q  [NUM_SPRITES];
  logic signed [COORD_W-1:0] x_d  [NUM_SPRITES];
  logic signed [COORD_W-1:0] y_q  [NUM_SPRITES];
  logic signed [COORD_W-1:0] y_d  [NUM_SPRITES];
  logic signed [COORD_W-1:0] xv_q [NUM_SPRITES];
  logic signed [COORD_W-1:0] xv_d [NUM_SPRITES];
  logic signed [COORD_W-1:0] yv_q [NUM_SPRITES];
  logic signed [COORD_W-1:0] yv_d [NUM_SPRITES];
  logic signed [COORD_W-1:0] step_x_pos, step_x_vel, step_y_pos, step_y_vel;
  logic                      vblank_edge;

  assign vblank_edge = i_vert_blank && !vblank_q;

  sprite_axis_step #(.COORD_W(COORD_W)) u_step_x (
    .i_pos(x_q[idx_q]), .i_vel(xv_q[idx_q]), .i_max(X_MAX_S),
    .o_pos(step_x_pos), .o_vel(step_x_vel)
  );

  sprite_axis_step #(.COORD_W(COORD_W)) u_step_y (
    .i_pos(y_q[idx_q]), .i_vel(yv_q[idx_q]), .i_max(Y_MAX_S),
    .o_pos(step_y_pos), .o_vel(step_y_vel)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    x_d          = x_q;
    y_d          = y_q;
    xv_d         = xv_q;
    yv_d         = yv_q;
    o_cfg_ready  = 1'b0;
    o_busy       = 1'b0;
    o_frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_cfg_ready = 1'b1;
        // The write lands on the same edge that starts a sweep, so the sweep sees it.
        if (i_cfg_valid) begin
          case (i_cfg_field)
            CFG_X:    x_d[i_cfg_sprite]  = i_cfg_data;
            CFG_Y:    y_d[i_cfg_sprite]  = i_cfg_data;
            CFG_XVEL: xv_d[i_cfg_sprite] = i_cfg_data;
            default:  yv_d[i_cfg_sprite] = i_cfg_data;
          endcase
        end
        if (vblank_edge) begin
          state_d = ST_UPDATE;
          idx_d   = '0;
        end
      end
      ST_UPDATE: begin
        o_busy       = 1'b1;
        x_d[idx_q]   = step_x_pos;
        xv_d[idx_q]  = step_x_vel;
        y_d[idx_q]   = step_y_pos;
        yv_d[idx_q]  = step_y_vel;
        if (idx_q == IDX_W'(NUM_SPRITES-1)) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        o_busy       = 1'b1;
        o_frame_done = 1'b1;
        count_d      = count_q + 16'd1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_pix_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      vblank_q <= 1'b1;
      count_q  <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        xv_q[i] <= COORD_W'(RST_X_VEL);
        yv_q[i] <= COORD_W'(RST_Y_VEL);
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      vblank_q <= i_vert_blank;
      count_q  <= count_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xv_q     <= xv_d;
      yv_q     <= yv_d;
    end
  end

  always_comb begin
    o_x_coords = '0;
    o_y_coords = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      o_x_coords[i*COORD_W +: COORD_W] = x_q[i];
      o_y_coords[i*COORD_W +: COORD_W] = y_q[i];
    end
  end

  assign o_frame_count = count_q;
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: directed frame scenarios plus random config/vblank traffic.
module tb_sprite_motion_ctrl;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int XM = 200;
  localparam int YM = 150;
  localparam int PW = N * W;
  localparam int EW = 2 * PW + 16;

  logic          clk;
  logic          rst;
  logic          vb;
  logic          cfg_valid;
  logic [1:0]    cfg_sprite;
  logic [1:0]    cfg_field;
  logic [W-1:0]  cfg_data;
  logic          cfg_ready;
  logic [PW-1:0] x_coords, y_coords;
  logic          busy, frame_done;
  logic [15:0]   frame_count;
  sprite_pkg::state_t dbg_state;

  int total = 0;
  int bad   = 0;
  int frames_seen = 0;
  int exp_frames  = 0;

  logic [EW-1:0] exp_q[$];

  int mx[N], my[N], mvx[N], mvy[N];
  int m_cnt;

  sprite_motion_ctrl #(
    .NUM_SPRITES(N), .COORD_W(W), .X_MAX(XM), .Y_MAX(YM), .RST_X_VEL(3), .RST_Y_VEL(2)
  ) dut (
    .i_pix_clk(clk), .i_reset(rst), .i_vert_blank(vb),
    .i_cfg_valid(cfg_valid), .i_cfg_sprite(cfg_sprite), .i_cfg_field(cfg_field),
    .i_cfg_data(cfg_data), .o_cfg_ready(cfg_ready),
    .o_x_coords(x_coords), .o_y_coords(y_coords), .o_busy(busy),
    .o_frame_done(frame_done), .o_frame_count(frame_count), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference model
  function automatic int neg_sat(input int v);
    return (v == -32768) ? 32767 : -v;
  endfunction

  function automatic void axis(input int max_v, input int p, input int v, output int np, output int nv);
    int n;
    n  = p + v;
    np = n;
    nv = v;
    if (n >= max_v) begin
      np = max_v - 1;
      nv = neg_sat(v);
    end else if (n < 0) begin
      np = 0;
      nv = neg_sat(v);
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 0; my[i] = 0; mvx[i] = 3; mvy[i] = 2;
    end
    m_cnt = 0;
  endtask

  task automatic model_write(input int sp, input int f, input int d);
    case (f)
      0: mx[sp]  = d;
      1: my[sp]  = d;
      2: mvx[sp] = d;
      default: mvy[sp] = d;
    endcase
  endtask

  task automatic model_sweep();
    logic [PW-1:0] ex, ey;
    int np, nv;
    for (int i = 0; i < N; i++) begin
      axis(XM, mx[i], mvx[i], np, nv); mx[i] = np; mvx[i] = nv;
      axis(YM, my[i], mvy[i], np, nv); my[i] = np; mvy[i] = nv;
      ex[i*W +: W] = W'(mx[i]);
      ey[i*W +: W] = W'(my[i]);
    end
    m_cnt = (m_cnt + 1) % 65536;
    exp_q.push_back({ex, ey, 16'(m_cnt)});
    exp_frames++;
  endtask

  // driver tasks; all inputs change 1 time unit after a rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int sp, input int f, input int d, output int waits);
    logic done;
    done = 1'b0;
    waits = 0;
    cfg_valid  = 1'b1;
    cfg_sprite = 2'(sp);
    cfg_field  = 2'(f);
    cfg_data   = W'(d);
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clk);
      if (cfg_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    cfg_valid = 1'b0;
    if (!done) check("cfg_accept_timeout", 0, 1);
    else model_write(sp, f, d);
  endtask

  task automatic pulse();
    vb = 1'b1;
    model_sweep();
    repeat (8) tick();
    vb = 1'b0;
    repeat (2) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, x_coords, '0);
    check({tag, "_y"}, y_coords, '0);
    check({tag, "_busy"}, PW'(busy), 0);
    check({tag, "_done"}, PW'(frame_done), 0);
    check({tag, "_count"}, PW'(frame_count), 0);
    check({tag, "_ready"}, PW'(cfg_ready), 1);
  endtask

  function automatic int rand_val();
    case ($urandom_range(0, 5))
      0: return -32768;
      1: return 32767;
      2: return $urandom_range(0, 600) - 300;
      default: return $urandom_range(0, 260) - 30;
    endcase
  endfunction

  // scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        frames_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_frame_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("frame_x", x_coords, e[EW-1 -: PW]);
          check("frame_y", y_coords, e[PW+15 -: PW]);
          check("frame_busy_ready", PW'({busy, cfg_ready}), PW'(2'b10));
          @(negedge clk);
          check("frame_count", PW'(frame_count), PW'(e[15:0]));
        end
      end
    end
  end

  // stimulus
  initial begin
    int w;
    int saw_busy;
    rst = 1'b1; vb = 1'b0; cfg_valid = 1'b0; cfg_sprite = '0; cfg_field = '0; cfg_data = '0;
    model_reset();
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) tick();

    repeat (3) pulse();
    check("s0_x_after3", PW'(x_coords[15:0]), 9);
    check("s0_y_after3", PW'(y_coords[15:0]), 6);

    cfg_write(1, 0, 198, w);
    cfg_write(1, 2, 3, w);
    pulse();
    check("s1_x_bounce_hi", PW'(x_coords[31:16]), 199);
    pulse();
    check("s1_x_after_bounce", PW'(x_coords[31:16]), 196);

    cfg_write(2, 1, 1, w);
    cfg_write(2, 3, -5, w);
    pulse();
    check("s2_y_bounce_lo", PW'(y_coords[47:32]), 0);

    // config write in the same cycle as the vblank edge
    vb = 1'b1; cfg_valid = 1'b1; cfg_sprite = 2'd3; cfg_field = 2'd0; cfg_data = W'(100);
    model_write(3, 0, 100);
    model_sweep();
    tick();
    cfg_valid = 1'b0;
    repeat (7) tick();
    vb = 1'b0;
    repeat (2) tick();

    // config request raised during the sweep is held off until IDLE
    vb = 1'b1;
    model_sweep();
    tick();
    cfg_write(0, 3, -1, w);
    check("cfg_holdoff_cycles", PW'(w), PW'(N + 1));
    repeat (3) tick();
    vb = 1'b0;
    repeat (2) tick();

    // second rising edge inside a sweep is ignored
    vb = 1'b1;
    model_sweep();
    tick();
    vb = 1'b0;
    tick();
    vb = 1'b1;
    repeat (10) tick();
    check("ignored_edge_frames", PW'(frames_seen), PW'(exp_frames));
    vb = 1'b0;
    repeat (2) tick();

    // most-negative velocity bounce at 0 saturates to max positive
    cfg_write(0, 0, 0, w);
    cfg_write(0, 2, -32768, w);
    pulse();
    pulse();
    check("s0_x_sat_bounce", PW'(x_coords[15:0]), 199);

    // reset mid-sweep, vblank still high at release
    vb = 1'b1;
    model_sweep();
    tick();
    tick();
    rst = 1'b1;
    exp_q.delete();
    exp_frames--;
    model_reset();
    #1;
    check_reset_outputs("midsweep_reset");
    repeat (2) tick();
    rst = 1'b0;
    saw_busy = 0;
    repeat (10) begin
      tick();
      if (busy) saw_busy = 1;
    end
    check("no_sweep_after_release", PW'(saw_busy), 0);
    vb = 1'b0;
    repeat (2) tick();
    pulse();
    check("post_reset_s0_x", PW'(x_coords[15:0]), 3);

    // random traffic
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) pulse();
      else cfg_write($urandom_range(0, N - 1), $urandom_range(0, 3), rand_val(), w);
    end
    pulse();

    repeat (5) tick();
    check("frames_total", PW'(frames_seen), PW'(exp_frames));
    check("queue_drained", PW'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
